// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle between the multicycle control FSM and the datapath.
//                Carries the decoded opcode and ALU zero flag toward the
//                controller and every datapath strobe back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
    parameter int OPW = 6
);

    // Datapath -> controller
    logic [OPW-1:0] op;
    logic           zero;

    // Controller -> datapath
    logic           PCWre;
    logic           IRWre;
    logic           RegWre;
    logic [1:0]     RegDst;
    logic           WrRegData;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic [2:0]     ALUOp;
    logic           ExtSel;
    logic           DataMemRW;
    logic           DBDataSrc;
    logic [1:0]     PCSrc;
    logic           Halted;

    // Controller side: consumes opcode/flag, produces strobes
    modport master (
        input  op,
        input  zero,
        output PCWre,
        output IRWre,
        output RegWre,
        output RegDst,
        output WrRegData,
        output ALUSrcA,
        output ALUSrcB,
        output ALUOp,
        output ExtSel,
        output DataMemRW,
        output DBDataSrc,
        output PCSrc,
        output Halted
    );

    // Datapath side: produces opcode/flag, consumes strobes
    modport slave (
        output op,
        output zero,
        input  PCWre,
        input  IRWre,
        input  RegWre,
        input  RegDst,
        input  WrRegData,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUOp,
        input  ExtSel,
        input  DataMemRW,
        input  DBDataSrc,
        input  PCSrc,
        input  Halted
    );

endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multicycle CPU control FSM. Sequences IF/ID/EXE/MEM/WB and
//                drives all datapath strobes combinationally from the current
//                state, the opcode held in the IR and the ALU zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int OPW = 6
) (
    input  wire logic         clk,
    input  wire logic         RST,
    control_unit_if.master    bus
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    // ALU function codes
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_SLL = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_AND = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b110;

    // Next-PC source select
    localparam logic [1:0] C_PC_INC  = 2'b00;
    localparam logic [1:0] C_PC_BR   = 2'b01;
    localparam logic [1:0] C_PC_RS   = 2'b10;
    localparam logic [1:0] C_PC_JMP  = 2'b11;

    // Destination register select
    localparam logic [1:0] C_DST_RT  = 2'b00;
    localparam logic [1:0] C_DST_RD  = 2'b01;
    localparam logic [1:0] C_DST_RA  = 2'b10;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_BR  = 4'd3,
        S_EXE_MEM = 4'd4,
        S_MEM     = 4'd5,
        S_WB_R    = 4'd6,
        S_WB_LW   = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // ALU-class decode of the held opcode
    logic       alu_valid;
    logic [2:0] alu_code;
    logic       alu_a_shamt;
    logic       alu_b_imm;
    logic       alu_sext;

    // Ungated strobe values from the FSM
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_data;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       data_mem_rw;
    logic       db_data_src;
    logic [1:0] pc_src;
    logic       halted;

    // State register; reset aborts any in-flight instruction and restarts fetch
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode ALU-class opcodes into function code and operand selects
    always_comb begin
        alu_valid   = 1'b1;
        alu_code    = C_ALU_ADD;
        alu_a_shamt = 1'b0;
        alu_b_imm   = 1'b0;
        alu_sext    = 1'b0;
        case (bus.op)
            OP_ADD:  alu_code = C_ALU_ADD;
            OP_SUB:  alu_code = C_ALU_SUB;
            OP_ADDI: begin
                alu_code  = C_ALU_ADD;
                alu_b_imm = 1'b1;
                alu_sext  = 1'b1;
            end
            OP_OR:   alu_code = C_ALU_OR;
            OP_AND:  alu_code = C_ALU_AND;
            OP_ORI:  begin
                alu_code  = C_ALU_OR;
                alu_b_imm = 1'b1;
                alu_sext  = 1'b0;
            end
            OP_SLL:  begin
                alu_code    = C_ALU_SLL;
                alu_a_shamt = 1'b1;
            end
            OP_SLT:  alu_code = C_ALU_SLT;
            default: alu_valid = 1'b0;
        endcase
    end

    // Next-state and strobe generation; every strobe defaults to inactive
    always_comb begin
        state_d     = state_q;
        pc_wre      = 1'b0;
        ir_wre      = 1'b0;
        reg_wre     = 1'b0;
        reg_dst     = C_DST_RT;
        wr_reg_data = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = C_ALU_ADD;
        ext_sel     = 1'b0;
        data_mem_rw = 1'b0;
        db_data_src = 1'b0;
        pc_src      = C_PC_INC;
        halted      = 1'b0;

        case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                state_d = S_ID;
            end

            S_ID: begin
                if (bus.op == OP_J) begin
                    pc_wre  = 1'b1;
                    pc_src  = C_PC_JMP;
                    state_d = S_IF;
                end else if (bus.op == OP_JR) begin
                    pc_wre  = 1'b1;
                    pc_src  = C_PC_RS;
                    state_d = S_IF;
                end else if (bus.op == OP_JAL) begin
                    // Link PC+4 into $31 in the same cycle as the jump
                    pc_wre      = 1'b1;
                    pc_src      = C_PC_JMP;
                    reg_wre     = 1'b1;
                    reg_dst     = C_DST_RA;
                    wr_reg_data = 1'b0;
                    state_d     = S_IF;
                end else if (bus.op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (bus.op == OP_BEQ) begin
                    state_d = S_EXE_BR;
                end else if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
                    state_d = S_EXE_MEM;
                end else if (alu_valid) begin
                    state_d = S_EXE_R;
                end else begin
                    // Unknown opcode: park rather than execute garbage
                    state_d = S_HALT;
                end
            end

            S_EXE_R: begin
                alu_op    = alu_code;
                alu_src_a = alu_a_shamt;
                alu_src_b = alu_b_imm;
                ext_sel   = alu_sext;
                state_d   = alu_valid ? S_WB_R : S_HALT;
            end

            S_WB_R: begin
                // ALU controls held so the result stays stable through writeback
                alu_op      = alu_code;
                alu_src_a   = alu_a_shamt;
                alu_src_b   = alu_b_imm;
                ext_sel     = alu_sext;
                reg_wre     = 1'b1;
                wr_reg_data = 1'b1;
                db_data_src = 1'b0;
                reg_dst     = alu_b_imm ? C_DST_RT : C_DST_RD;
                pc_wre      = 1'b1;
                pc_src      = C_PC_INC;
                state_d     = S_IF;
            end

            S_EXE_BR: begin
                alu_op  = C_ALU_SUB;
                ext_sel = 1'b1;
                pc_wre  = 1'b1;
                pc_src  = bus.zero ? C_PC_BR : C_PC_INC;
                state_d = S_IF;
            end

            S_EXE_MEM: begin
                alu_op    = C_ALU_ADD;
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                state_d   = S_MEM;
            end

            S_MEM: begin
                // Effective address must stay valid during the memory access
                alu_op    = C_ALU_ADD;
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                if (bus.op == OP_SW) begin
                    data_mem_rw = 1'b1;
                    pc_wre      = 1'b1;
                    pc_src      = C_PC_INC;
                    state_d     = S_IF;
                end else if (bus.op == OP_LW) begin
                    state_d = S_WB_LW;
                end else begin
                    state_d = S_HALT;
                end
            end

            S_WB_LW: begin
                reg_wre     = 1'b1;
                reg_dst     = C_DST_RT;
                wr_reg_data = 1'b1;
                db_data_src = 1'b1;
                pc_wre      = 1'b1;
                pc_src      = C_PC_INC;
                state_d     = S_IF;
            end

            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end

            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Strobes that change architectural state are suppressed while reset is held
    assign bus.PCWre     = pc_wre      & RST;
    assign bus.IRWre     = ir_wre      & RST;
    assign bus.RegWre    = reg_wre     & RST;
    assign bus.DataMemRW = data_mem_rw & RST;
    assign bus.Halted    = halted      & RST;
    assign bus.RegDst    = reg_dst;
    assign bus.WrRegData = wr_reg_data;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ExtSel    = ext_sel;
    assign bus.DBDataSrc = db_data_src;
    assign bus.PCSrc     = pc_src;

    // PC update and instruction fetch are mutually exclusive
    a_no_pc_ir_overlap : assert property (@(posedge clk) disable iff (!RST)
        !(bus.PCWre && bus.IRWre));

    // Instruction register only loads in the fetch state
    a_ir_only_in_if : assert property (@(posedge clk) disable iff (!RST)
        bus.IRWre |-> (state_q == S_IF));

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed-vector scoreboard bench for control_unit. A driver
//                applies one cycle of stimulus at a time and queues the
//                hand-computed strobe vector; a monitor compares each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    // Packed vector order:
    // {PCWre,IRWre,RegWre,RegDst[1:0],WrRegData,ALUSrcA,ALUSrcB,ALUOp[2:0],
    //  ExtSel,DataMemRW,DBDataSrc,PCSrc[1:0],Halted}
    typedef struct {
        logic [16:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic RST;
    exp_t q[$];
    int   n_checks;
    int   n_fail;

    control_unit_if #(.OPW(6)) bus ();

    control_unit #(.OPW(6)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] v(
        input logic pc, input logic ir, input logic rw, input logic [1:0] rd,
        input logic wd, input logic sa, input logic sb, input logic [2:0] aop,
        input logic ext, input logic dm, input logic dbs, input logic [1:0] pcs,
        input logic h);
        return {pc, ir, rw, rd, wd, sa, sb, aop, ext, dm, dbs, pcs, h};
    endfunction

    localparam logic [16:0] E_ZERO = 17'b0;
    localparam logic [16:0] E_IF   = 17'b0_1_0_00_0_0_0_000_0_0_0_00_0;
    localparam logic [16:0] E_HALT = 17'b0_0_0_00_0_0_0_000_0_0_0_00_1;

    // One clock of stimulus plus the strobe vector expected during that clock
    task automatic step(input logic [5:0] o, input logic z, input logic r,
                        input logic [16:0] e, input string nm);
        exp_t it;
        @(posedge clk);
        #1;
        bus.op   = o;
        bus.zero = z;
        RST      = r;
        it.exp   = e;
        it.name  = nm;
        q.push_back(it);
    endtask

    // R-type / immediate instruction: IF, ID, EXE_R, WB_R
    task automatic alu_instr(input logic [5:0] o, input logic [2:0] aop,
                             input logic sa, input logic sb, input logic ext,
                             input logic [1:0] rd, input string nm);
        step(o, 1'b0, 1'b1, E_IF, {nm, "_if"});
        step(o, 1'b0, 1'b1, E_ZERO, {nm, "_id"});
        step(o, 1'b0, 1'b1, v(0,0,0,2'b00,0,sa,sb,aop,ext,0,0,2'b00,0), {nm, "_exe"});
        step(o, 1'b0, 1'b1, v(1,0,1,rd,1,sa,sb,aop,ext,0,0,2'b00,0), {nm, "_wb"});
    endtask

    // Scoreboard monitor: compares one queued expectation per falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            logic [16:0] act;
            it  = q.pop_front();
            act = {bus.PCWre, bus.IRWre, bus.RegWre, bus.RegDst, bus.WrRegData,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ExtSel, bus.DataMemRW,
                   bus.DBDataSrc, bus.PCSrc, bus.Halted};
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b0;
        bus.op   = 6'b0;
        bus.zero = 1'b0;

        // Reset held: every strobe low
        step(6'b000000, 1'b0, 1'b0, E_ZERO, "reset_hold");

        // add / sub / or / and / slt: register destination rd
        alu_instr(6'b000000, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01, "add");
        alu_instr(6'b000001, 3'b001, 1'b0, 1'b0, 1'b0, 2'b01, "sub");
        alu_instr(6'b010000, 3'b011, 1'b0, 1'b0, 1'b0, 2'b01, "or");
        alu_instr(6'b010001, 3'b100, 1'b0, 1'b0, 1'b0, 2'b01, "and");
        alu_instr(6'b100110, 3'b110, 1'b0, 1'b0, 1'b0, 2'b01, "slt");
        // sll uses shamt on A
        alu_instr(6'b011000, 3'b010, 1'b1, 1'b0, 1'b0, 2'b01, "sll");
        // addi sign-extends, ori zero-extends; both write rt
        alu_instr(6'b000010, 3'b000, 1'b0, 1'b1, 1'b1, 2'b00, "addi");
        alu_instr(6'b010010, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00, "ori");

        // beq taken
        step(6'b110100, 1'b1, 1'b1, E_IF, "beq_t_if");
        step(6'b110100, 1'b1, 1'b1, E_ZERO, "beq_t_id");
        step(6'b110100, 1'b1, 1'b1, v(1,0,0,2'b00,0,0,0,3'b001,1,0,0,2'b01,0), "beq_t_exe");
        // beq not taken
        step(6'b110100, 1'b0, 1'b1, E_IF, "beq_n_if");
        step(6'b110100, 1'b0, 1'b1, E_ZERO, "beq_n_id");
        step(6'b110100, 1'b0, 1'b1, v(1,0,0,2'b00,0,0,0,3'b001,1,0,0,2'b00,0), "beq_n_exe");

        // lw: five cycles, no memory write
        step(6'b110001, 1'b0, 1'b1, E_IF, "lw_if");
        step(6'b110001, 1'b0, 1'b1, E_ZERO, "lw_id");
        step(6'b110001, 1'b0, 1'b1, v(0,0,0,2'b00,0,0,1,3'b000,1,0,0,2'b00,0), "lw_exe");
        step(6'b110001, 1'b0, 1'b1, v(0,0,0,2'b00,0,0,1,3'b000,1,0,0,2'b00,0), "lw_mem");
        step(6'b110001, 1'b0, 1'b1, v(1,0,1,2'b00,1,0,0,3'b000,0,0,1,2'b00,0), "lw_wb");

        // sw: four cycles, write memory, no register write
        step(6'b110000, 1'b0, 1'b1, E_IF, "sw_if");
        step(6'b110000, 1'b0, 1'b1, E_ZERO, "sw_id");
        step(6'b110000, 1'b0, 1'b1, v(0,0,0,2'b00,0,0,1,3'b000,1,0,0,2'b00,0), "sw_exe");
        step(6'b110000, 1'b0, 1'b1, v(1,0,0,2'b00,0,0,1,3'b000,1,1,0,2'b00,0), "sw_mem");

        // Jumps retire in ID
        step(6'b111000, 1'b0, 1'b1, E_IF, "j_if");
        step(6'b111000, 1'b0, 1'b1, v(1,0,0,2'b00,0,0,0,3'b000,0,0,0,2'b11,0), "j_id");
        step(6'b111001, 1'b0, 1'b1, E_IF, "jr_if");
        step(6'b111001, 1'b0, 1'b1, v(1,0,0,2'b00,0,0,0,3'b000,0,0,0,2'b10,0), "jr_id");
        step(6'b111010, 1'b0, 1'b1, E_IF, "jal_if");
        step(6'b111010, 1'b0, 1'b1, v(1,0,1,2'b10,0,0,0,3'b000,0,0,0,2'b11,0), "jal_id");
        step(6'b111010, 1'b0, 1'b1, E_IF, "jal_next_if");
        step(6'b111000, 1'b0, 1'b1, v(1,0,0,2'b00,0,0,0,3'b000,0,0,0,2'b11,0), "j2_id");

        // Reset asserted during WB_R of add: write strobes suppressed, refetch after
        step(6'b000000, 1'b0, 1'b1, E_IF, "rst_add_if");
        step(6'b000000, 1'b0, 1'b1, E_ZERO, "rst_add_id");
        step(6'b000000, 1'b0, 1'b1, E_ZERO, "rst_add_exe");
        step(6'b000000, 1'b0, 1'b0, E_ZERO, "rst_mid_wb");
        step(6'b000000, 1'b0, 1'b1, E_IF, "rst_release_if");
        step(6'b000000, 1'b0, 1'b1, E_ZERO, "rst_add2_id");
        step(6'b000000, 1'b0, 1'b1, E_ZERO, "rst_add2_exe");
        step(6'b000000, 1'b0, 1'b1, v(1,0,1,2'b01,1,0,0,3'b000,0,0,0,2'b00,0), "rst_add2_wb");

        // halt: parks for good until reset
        step(6'b111111, 1'b0, 1'b1, E_IF, "halt_if");
        step(6'b111111, 1'b0, 1'b1, E_ZERO, "halt_id");
        for (int i = 0; i < 20; i++) begin
            step(6'b000000, 1'b0, 1'b1, E_HALT, "halt_park");
        end
        step(6'b000000, 1'b0, 1'b0, E_ZERO, "halt_rst");

        // Undefined opcode behaves like halt
        step(6'b101010, 1'b0, 1'b1, E_IF, "undef_if");
        step(6'b101010, 1'b0, 1'b1, E_ZERO, "undef_id");
        for (int i = 0; i < 20; i++) begin
            step(6'b101010, 1'b0, 1'b1, E_HALT, "undef_park");
        end
        step(6'b101010, 1'b0, 1'b0, E_ZERO, "undef_rst");
        step(6'b000001, 1'b0, 1'b1, E_IF, "undef_after_if");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
